borg_plane_scanner: RTL and testbench

- PWM scan engine for the Farbborg LED cube; sits directly downstream of the Farbborg brightness frame buffer and drives the cube's shift-register/latch pins (lsr_*, latch_data, psr_*, col_enable).
- Reads packed 8-bit brightness values plane by plane.
- Compares each value against a running PWM step counter, shifts the resulting on/off bytes into the column latches, then enables the columns for a fixed display window.
- Pulses frame_done once per complete cube refresh so firmware can swap buffers.

---
 rtl/borg_plane_scanner.sv | 168 ++++++++++++++++
 tb/tb_borg_plane_scanner.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/borg_plane_scanner.sv
// PWM scan engine for the Farbborg LED cube: fetches brightness bytes plane by
// plane, thresholds them against the PWM step and drives the latch/plane shift chains.
module borg_plane_scanner #(
    parameter int PLANES      = 5,
    parameter int LATCHES     = 8,
    parameter int PWM_STEPS   = 255,
    parameter int DISP_CYCLES = 64,
    parameter int ADR_W       = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    output logic [ADR_W-1:0] buf_adr,
    input  logic [63:0]      buf_dat,
    output logic             frame_done,
    output logic             lsr_clr,
    output logic             lsr_d,
    output logic             lsr_c,
    output logic [7:0]       latch_data,
    output logic             psr_c,
    output logic             psr_d,
    output logic             col_enable
);

    localparam int PL_W = (PLANES > 1) ? $clog2(PLANES) : 1;
    localparam int LT_W = (LATCHES > 1) ? $clog2(LATCHES) : 1;
    localparam int DC_W = (DISP_CYCLES > 1) ? $clog2(DISP_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        PSR_SET,
        PSR_CLK,
        LSR_CLR,
        FETCH,
        DATA,
        LCLK,
        DISP
    } state_t;

    state_t            state_reg, state_next;
    logic [PL_W-1:0]   plane_reg, plane_next;
    logic [7:0]        step_reg, step_next;
    logic [LT_W-1:0]   latch_reg, latch_next;
    logic [DC_W-1:0]   disp_reg, disp_next;
    logic              need_psr_reg, need_psr_next;
    logic              frame_done_next;
    logic [ADR_W-1:0]  adr_next;
    logic [7:0]        hit;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_cmp
            assign hit[gi] = buf_dat[8*gi +: 8] > step_reg;
        end
    endgenerate

    always_comb begin
        state_next      = state_reg;
        plane_next      = plane_reg;
        step_next       = step_reg;
        latch_next      = latch_reg;
        disp_next       = disp_reg;
        need_psr_next   = need_psr_reg;
        frame_done_next = 1'b0;

        case (state_reg)
            IDLE: begin
                // A resume mid-plane skips the plane shift; a new plane needs it.
                if (enable) begin
                    state_next = need_psr_reg ? PSR_SET : LSR_CLR;
                end
            end
            PSR_SET: begin
                need_psr_next = 1'b0;
                state_next    = PSR_CLK;
            end
            PSR_CLK: state_next = LSR_CLR;
            LSR_CLR: begin
                latch_next = '0;
                state_next = FETCH;
            end
            FETCH: state_next = DATA;
            DATA:  state_next = LCLK;
            LCLK: begin
                if (latch_reg == LT_W'(LATCHES - 1)) begin
                    disp_next  = '0;
                    state_next = DISP;
                end else begin
                    latch_next = latch_reg + 1'b1;
                    state_next = FETCH;
                end
            end
            DISP: begin
                if (disp_reg == DC_W'(DISP_CYCLES - 1)) begin
                    if (step_reg == 8'(PWM_STEPS - 1)) begin
                        step_next     = '0;
                        need_psr_next = 1'b1;
                        state_next    = PSR_SET;
                        if (plane_reg == PL_W'(PLANES - 1)) begin
                            plane_next      = '0;
                            frame_done_next = 1'b1;
                        end else begin
                            plane_next = plane_reg + 1'b1;
                        end
                    end else begin
                        step_next  = step_reg + 1'b1;
                        state_next = LSR_CLR;
                    end
                    if (!enable) begin
                        state_next = IDLE;
                    end
                end else begin
                    disp_next = disp_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        adr_next = ADR_W'(int'(plane_next) * LATCHES + int'(latch_next));
    end

    // Outputs are decoded from the state being entered so they line up with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            plane_reg    <= '0;
            step_reg     <= '0;
            latch_reg    <= '0;
            disp_reg     <= '0;
            need_psr_reg <= 1'b1;
            buf_adr      <= '0;
            frame_done   <= 1'b0;
            lsr_clr      <= 1'b0;
            lsr_d        <= 1'b0;
            lsr_c        <= 1'b0;
            latch_data   <= '0;
            psr_c        <= 1'b0;
            psr_d        <= 1'b0;
            col_enable   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            plane_reg    <= plane_next;
            step_reg     <= step_next;
            latch_reg    <= latch_next;
            disp_reg     <= disp_next;
            need_psr_reg <= need_psr_next;
            frame_done   <= frame_done_next;
            psr_c        <= (state_next == PSR_CLK);
            lsr_clr      <= (state_next == LSR_CLR);
            lsr_c        <= (state_next == LCLK);
            col_enable   <= (state_next == DISP);
            if (state_next == PSR_SET) begin
                psr_d <= (plane_next == '0);
            end
            if (state_next == FETCH) begin
                buf_adr <= adr_next;
            end
            if (state_next == DATA) begin
                lsr_d <= (latch_next == '0);
            end
            // buf_dat is valid during DATA, one cycle after the FETCH address.
            if (state_reg == DATA) begin
                latch_data <= hit;
            end
        end
    end

endmodule

// File: tb/tb_borg_plane_scanner.sv
// Directed bench for borg_plane_scanner on a 2-plane, 2-latch, 4-step cube
// with a registered-read frame buffer model.
module tb_borg_plane_scanner;

    localparam int PLANES      = 2;
    localparam int LATCHES     = 2;
    localparam int PWM_STEPS   = 4;
    localparam int DISP_CYCLES = 3;
    localparam int ADR_W       = 6;

    // Hand-computed latch bytes per address and step.
    localparam logic [7:0] LD_EXP [4][4] = '{
        '{8'hFE, 8'hFC, 8'hF8, 8'hF0},
        '{8'h7A, 8'h72, 8'h62, 8'h42},
        '{8'hFF, 8'hFF, 8'hFF, 8'hFF},
        '{8'h00, 8'h00, 8'h00, 8'h00}
    };

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             enable = 1'b0;
    logic [ADR_W-1:0] buf_adr;
    logic [63:0]      buf_dat = '0;
    logic             frame_done, lsr_clr, lsr_d, lsr_c, psr_c, psr_d, col_enable;
    logic [7:0]       latch_data;
    logic [63:0]      mem [0:63];

    int total = 0;
    int bad   = 0;
    int n_psr = 0, n_lsr = 0, n_clr = 0, n_col = 0, n_fd = 0;

    borg_plane_scanner #(
        .PLANES(PLANES), .LATCHES(LATCHES), .PWM_STEPS(PWM_STEPS),
        .DISP_CYCLES(DISP_CYCLES), .ADR_W(ADR_W)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .buf_adr(buf_adr),
        .buf_dat(buf_dat), .frame_done(frame_done), .lsr_clr(lsr_clr),
        .lsr_d(lsr_d), .lsr_c(lsr_c), .latch_data(latch_data),
        .psr_c(psr_c), .psr_d(psr_d), .col_enable(col_enable)
    );

    always #5 clk = ~clk;

    always @(posedge clk) buf_dat <= mem[buf_adr];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tk;
        @(posedge clk);
        #1;
        n_psr += int'(psr_c);
        n_lsr += int'(lsr_c);
        n_clr += int'(lsr_clr);
        n_col += int'(col_enable);
        n_fd  += int'(frame_done);
    endtask

    task automatic chk_zero(input string tag);
        chk(tag, {buf_adr, frame_done, lsr_clr, lsr_d, lsr_c, latch_data, psr_c, psr_d, col_enable}, 64'd0);
    endtask

    // Walks one PWM step cycle by cycle; drop lowers enable after latch 0's clock,
    // cut returns after the first display cycle.
    task automatic run_step(input int pl, input int st, input bit newp, input bit fd,
                            input bit drop, input bit cut);
        int l0;
        int c0;
        l0 = n_lsr;
        c0 = n_col;
        if (newp) begin
            tk;
            chk("psr_set_d", psr_d, (pl == 0));
            chk("psr_set_c", psr_c, 0);
            chk("frame_done", frame_done, fd);
            tk;
            chk("psr_clk", psr_c, 1);
        end
        tk;
        chk("lsr_clr", lsr_clr, 1);
        chk("col_off", col_enable, 0);
        for (int l = 0; l < LATCHES; l++) begin
            tk;
            chk("buf_adr", buf_adr, pl * LATCHES + l);
            chk("lsr_c_low", lsr_c, 0);
            tk;
            chk("lsr_d", lsr_d, (l == 0));
            tk;
            chk("lsr_c_high", lsr_c, 1);
            chk("latch_data", latch_data, LD_EXP[pl * LATCHES + l][st]);
            if (drop && l == 0) enable = 1'b0;
        end
        for (int d = 0; d < DISP_CYCLES; d++) begin
            tk;
            chk("col_enable", col_enable, 1);
            if (cut) return;
        end
        chk("lsr_c_count", n_lsr - l0, 2);
        chk("col_count", n_col - c0, 3);
    endtask

    initial begin
        int a, b, c, d;
        for (int i = 0; i < 64; i++) mem[i] = '0;
        mem[0] = 64'h0706050403020100;
        mem[1] = 64'h00FF030201_00FF00;
        mem[2] = 64'h8080808080808080;
        mem[3] = 64'h0000000000000000;

        reset  = 1'b1;
        enable = 1'b1;
        repeat (3) begin
            tk;
            chk_zero("reset_outs");
        end
        reset = 1'b0;
        n_psr = 0;

        // One full frame: 2 planes x 4 steps.
        run_step(0, 0, 1, 0, 0, 0);
        run_step(0, 1, 0, 0, 0, 0);
        run_step(0, 2, 0, 0, 0, 0);
        run_step(0, 3, 0, 0, 0, 0);
        run_step(1, 0, 1, 0, 0, 0);
        run_step(1, 1, 0, 0, 0, 0);
        run_step(1, 2, 0, 0, 0, 0);
        run_step(1, 3, 0, 0, 0, 0);
        chk("psr_per_frame", n_psr, 2);
        chk("fd_before_wrap", n_fd, 0);
        run_step(0, 0, 1, 1, 0, 0);
        chk("fd_count", n_fd, 1);

        // Enable drop during the first latch clock of step 1.
        run_step(0, 1, 0, 0, 1, 0);
        tk;
        chk("idle_col", col_enable, 0);
        chk("idle_clr", lsr_clr, 0);
        a = n_lsr; b = n_clr; c = n_psr; d = n_col;
        repeat (4) tk;
        chk("idle_no_pulses", (n_lsr - a) + (n_clr - b) + (n_psr - c) + (n_col - d), 0);
        chk("idle_adr_hold", buf_adr, 1);
        enable = 1'b1;
        run_step(0, 2, 0, 0, 0, 0);

        // Reset in the middle of the display window.
        run_step(0, 3, 0, 0, 0, 1);
        reset = 1'b1;
        tk;
        chk_zero("reset_mid_disp");
        reset = 1'b0;
        run_step(0, 0, 1, 0, 0, 0);
        chk("fd_total", n_fd, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
